fft_stage_sequencer: RTL and testbench

FFT_STAGE_SEQUENCER -- requirements
Module: fft_stage_sequencer

---
 rtl/fft_stage_sequencer_pkg.sv | 41 ++++
 rtl/fft_stage_sequencer_if.sv | 30 +++
 rtl/fft_addr_gen.sv | 23 ++
 rtl/fft_stage_sequencer.sv | 140 ++++++++++++++
 tb/tb_fft_stage_sequencer.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_stage_sequencer_pkg.sv
// Shared types, defaults and address arithmetic for the FFT stage sequencer.
package fft_stage_sequencer_pkg;

    localparam int DEFAULT_N     = 256;
    localparam int DEFAULT_LOG2N = 8;
    // Widest supported transform (N = 1024); address math is done at this width.
    localparam int MAX_LOG2N     = 10;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        DRAIN = 3'd2,
        FIN   = 3'd3
    } state_t;

    typedef struct packed {
        logic [MAX_LOG2N-1:0] addr_a;
        logic [MAX_LOG2N-1:0] addr_b;
        logic [MAX_LOG2N-1:0] tw_idx;
    } bf_addr_t;

    // Radix-2 DIT pair addressing for pair p of a given stage, shifts and masks only.
    // With h = 1<<stage: group g = p>>stage, offset q = p&(h-1),
    // addr_a = g*2h + q, addr_b = addr_a + h, tw_idx = q << (log2n-1-stage).
    function automatic bf_addr_t calc_bf_addr(input logic [3:0]           stage,
                                              input logic [MAX_LOG2N-1:0] p,
                                              input logic [3:0]           log2n);
        logic [MAX_LOG2N-1:0] h;
        logic [MAX_LOG2N-1:0] g;
        logic [MAX_LOG2N-1:0] q;
        bf_addr_t             r;
        h        = MAX_LOG2N'(1) << stage;
        g        = p >> stage;
        q        = p & (h - MAX_LOG2N'(1));
        r.addr_a = (g << (stage + 4'd1)) + q;
        r.addr_b = r.addr_a + h;
        r.tw_idx = q << (log2n - 4'd1 - stage);
        return r;
    endfunction

endpackage

// File: rtl/fft_stage_sequencer_if.sv
// Control/address bundle between the stage sequencer and the shared butterfly.
interface fft_stage_sequencer_if
    import fft_stage_sequencer_pkg::*;
#(
    parameter int LOG2N = DEFAULT_LOG2N
);
    logic                       start;
    logic                       bf_ready;
    logic                       bf_done;
    logic                       bf_valid;
    logic [LOG2N-1:0]           addr_a;
    logic [LOG2N-1:0]           addr_b;
    logic [LOG2N-2:0]           tw_idx;
    logic [$clog2(LOG2N)-1:0]   stage;
    logic                       busy;
    logic                       done;
    logic                       err;

    // Sequencer side.
    modport master (
        input  start, bf_ready, bf_done,
        output bf_valid, addr_a, addr_b, tw_idx, stage, busy, done, err
    );

    // Controller / butterfly side.
    modport slave (
        output start, bf_ready, bf_done,
        input  bf_valid, addr_a, addr_b, tw_idx, stage, busy, done, err
    );
endinterface

// File: rtl/fft_addr_gen.sv
// Combinational butterfly address generator; the parent registers its outputs.
module fft_addr_gen
    import fft_stage_sequencer_pkg::*;
#(
    parameter int LOG2N = DEFAULT_LOG2N
) (
    input  logic [$clog2(LOG2N)-1:0] stage,
    input  logic [LOG2N-2:0]         p,
    output logic [LOG2N-1:0]         addr_a,
    output logic [LOG2N-1:0]         addr_b,
    output logic [LOG2N-2:0]         tw_idx
);
    bf_addr_t full;
    logic     unused_high_bits;

    assign full   = calc_bf_addr(4'(stage), MAX_LOG2N'(p), 4'(LOG2N));
    assign addr_a = full.addr_a[LOG2N-1:0];
    assign addr_b = full.addr_b[LOG2N-1:0];
    assign tw_idx = full.tw_idx[LOG2N-2:0];

    // Bits above LOG2N are always zero for in-range stages; sink them explicitly.
    assign unused_high_bits = ^full;
endmodule

// File: rtl/fft_stage_sequencer.sv
// Sequences the LOG2N radix-2 stages of an N-point FFT over one shared butterfly.
module fft_stage_sequencer
    import fft_stage_sequencer_pkg::*;
#(
    parameter int N     = DEFAULT_N,
    parameter int LOG2N = DEFAULT_LOG2N
) (
    input  logic                  clk,
    input  logic                  reset,
    fft_stage_sequencer_if.master bus
);
    localparam int               SW         = $clog2(LOG2N);
    localparam logic [LOG2N-1:0] HALF       = LOG2N'(N / 2);
    localparam logic [SW-1:0]    LAST_STAGE = SW'(LOG2N - 1);

    state_t           state, state_n;
    logic [SW-1:0]    stage, stage_n;
    logic [LOG2N-1:0] p, p_n;          // next pair to issue; reaches HALF when the stage is fully issued
    logic [LOG2N-1:0] c, c_n;          // butterfly write-backs seen this stage
    logic             valid_q, valid_n;
    logic [LOG2N-1:0] addr_a_q, addr_a_n;
    logic [LOG2N-1:0] addr_b_q, addr_b_n;
    logic [LOG2N-2:0] tw_q, tw_n;
    logic             err_q, err_n;

    logic [LOG2N-1:0] gen_a;
    logic [LOG2N-1:0] gen_b;
    logic [LOG2N-2:0] gen_tw;
    logic             done_ok;

    fft_addr_gen #(.LOG2N(LOG2N)) u_addr_gen (
        .stage  (stage),
        .p      (p[LOG2N-2:0]),
        .addr_a (gen_a),
        .addr_b (gen_b),
        .tw_idx (gen_tw)
    );

    // State and datapath registers, synchronous reset aborts any transform.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state    <= IDLE;
            stage    <= '0;
            p        <= '0;
            c        <= '0;
            valid_q  <= 1'b0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            tw_q     <= '0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_n;
            stage    <= stage_n;
            p        <= p_n;
            c        <= c_n;
            valid_q  <= valid_n;
            addr_a_q <= addr_a_n;
            addr_b_q <= addr_b_n;
            tw_q     <= tw_n;
            err_q    <= err_n;
        end
    end

    // Next-state, issue and completion bookkeeping.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path can infer a latch.
        state_n  = state;
        stage_n  = stage;
        p_n      = p;
        c_n      = c;
        valid_n  = 1'b0;
        addr_a_n = addr_a_q;
        addr_b_n = addr_b_q;
        tw_n     = tw_q;
        err_n    = err_q;

        // A write-back only counts while a stage is open and still owes results.
        done_ok = bus.bf_done && ((state == ISSUE) || (state == DRAIN)) && (c != HALF);
        if (done_ok) begin
            c_n = c + LOG2N'(1);
        end

        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_n = ISSUE;
                    stage_n = '0;
                    p_n     = '0;
                    c_n     = '0;
                    err_n   = 1'b0;
                end
            end
            ISSUE: begin
                // Leaving one cycle after the last request keeps bf_valid inside ISSUE.
                if (p == HALF) begin
                    state_n = DRAIN;
                end else if (bus.bf_ready) begin
                    valid_n  = 1'b1;
                    addr_a_n = gen_a;
                    addr_b_n = gen_b;
                    tw_n     = gen_tw;
                    p_n      = p + LOG2N'(1);
                end
            end
            DRAIN: begin
                if (c_n == HALF) begin
                    if (stage == LAST_STAGE) begin
                        state_n = FIN;
                    end else begin
                        state_n = ISSUE;
                        stage_n = stage + SW'(1);
                        p_n     = '0;
                        c_n     = '0;
                    end
                end
            end
            FIN: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Unexpected write-back wins over a start clearing err in the same cycle.
        if (bus.bf_done && !done_ok) begin
            err_n = 1'b1;
        end
    end

    assign bus.bf_valid = valid_q;
    assign bus.addr_a   = addr_a_q;
    assign bus.addr_b   = addr_b_q;
    assign bus.tw_idx   = tw_q;
    assign bus.stage    = stage;
    assign bus.busy     = (state == ISSUE) || (state == DRAIN);
    assign bus.done     = (state == FIN);
    assign bus.err      = err_q;
endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Directed bench for fft_stage_sequencer at N=256 with a 3-cycle echo butterfly.
module tb_fft_stage_sequencer;

    localparam int N     = 256;
    localparam int LOG2N = 8;
    localparam int HALF  = N / 2;

    typedef struct {
        int stage;
        int p;
        int addr_a;
        int addr_b;
        int tw;
    } addr_vec_t;

    logic clk;
    logic reset;

    fft_stage_sequencer_if #(.LOG2N(LOG2N)) bus ();

    fft_stage_sequencer #(.N(N), .LOG2N(LOG2N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_err;
    int cyc;
    int vcount [LOG2N];
    int obs_a  [LOG2N][HALF];
    int obs_b  [LOG2N][HALF];
    int obs_tw [LOG2N][HALF];
    int seq_err;
    int done_cnt;
    int busy_bad;
    int first_v0;
    int last_v0;
    bit prev_busy;
    bit aborted;
    logic [2:0] echo;
    addr_vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Reference addressing written with divide/multiply.
    function automatic void model(input int s, input int p, output int a, output int b, output int tw);
        int h;
        int g;
        int q;
        h  = 2 ** s;
        g  = p / h;
        q  = p % h;
        a  = g * 2 * h + q;
        b  = a + h;
        tw = q * ((N / 2) / h);
    endfunction

    function automatic int total_valids();
        int t;
        t = 0;
        for (int s = 0; s < LOG2N; s++) t += vcount[s];
        return t;
    endfunction

    // Observe this cycle's outputs, then drive the butterfly echo and bf_ready.
    task automatic cycle_io(input bit toggle);
        int s;
        int pi;
        int ea;
        int eb;
        int et;
        if (bus.bf_valid === 1'b1) begin
            s  = int'(bus.stage);
            pi = vcount[s];
            if (pi < HALF) begin
                model(s, pi, ea, eb, et);
                obs_a[s][pi]  = int'(bus.addr_a);
                obs_b[s][pi]  = int'(bus.addr_b);
                obs_tw[s][pi] = int'(bus.tw_idx);
                if (obs_a[s][pi] != ea || obs_b[s][pi] != eb || obs_tw[s][pi] != et) seq_err++;
            end else begin
                seq_err++;
            end
            vcount[s]++;
            if (s == 0) begin
                if (first_v0 < 0) first_v0 = cyc;
                last_v0 = cyc;
            end
            if (bus.busy !== 1'b1) seq_err++;
        end
        if (bus.done === 1'b1) begin
            done_cnt++;
            if (bus.busy !== 1'b0 || !prev_busy) busy_bad++;
        end
        prev_busy    = (bus.busy === 1'b1);
        bus.bf_done  = echo[2];
        echo         = {echo[1:0], bus.bf_valid};
        bus.bf_ready = toggle ? ~bus.bf_ready : 1'b1;
    endtask

    task automatic run_transform(input bit toggle, input int restart_stage, input int abort_stage,
                                 input string tag);
        bit restarted;
        restarted = 1'b0;
        for (int s = 0; s < LOG2N; s++) vcount[s] = 0;
        seq_err   = 0;
        done_cnt  = 0;
        busy_bad  = 0;
        first_v0  = -1;
        last_v0   = -1;
        echo      = '0;
        prev_busy = 1'b0;
        aborted   = 1'b0;
        bus.bf_ready = 1'b1;
        bus.start    = 1'b1;
        step();
        cycle_io(toggle);
        bus.start = 1'b0;
        for (int k = 0; k < 5000 && done_cnt == 0 && !aborted; k++) begin
            if (abort_stage >= 0 && int'(bus.stage) == abort_stage && vcount[abort_stage] == 60) begin
                reset       = 1'b1;
                echo        = '0;
                bus.bf_done = 1'b0;
                step();
                reset   = 1'b0;
                aborted = 1'b1;
            end else begin
                bus.start = (restart_stage >= 0 && !restarted && int'(bus.stage) == restart_stage &&
                             vcount[restart_stage] == 40);
                if (bus.start) restarted = 1'b1;
                step();
                cycle_io(toggle);
            end
        end
        bus.start = 1'b0;
        if (!aborted) begin
            check({tag, " done within budget"}, 32'(done_cnt), 1);
            repeat (10) begin
                step();
                cycle_io(toggle);
            end
            check({tag, " total bf_valid"}, 32'(total_valids()), LOG2N * HALF);
            check({tag, " addr sequence errors"}, 32'(seq_err), 0);
            check({tag, " done pulses"}, 32'(done_cnt), 1);
            check({tag, " busy/done alignment errors"}, 32'(busy_bad), 0);
            check({tag, " err after run"}, 32'(bus.err), 0);
            check({tag, " busy after run"}, 32'(bus.busy), 0);
        end
    endtask

    initial begin
        int base;
        n_checks = 0;
        n_err    = 0;
        cyc      = 0;
        echo     = '0;

        vecs[0] = '{stage: 0, p: 0,   addr_a: 0,   addr_b: 1,   tw: 0};
        vecs[1] = '{stage: 1, p: 3,   addr_a: 5,   addr_b: 7,   tw: 64};
        vecs[2] = '{stage: 7, p: 5,   addr_a: 5,   addr_b: 133, tw: 5};
        vecs[3] = '{stage: 2, p: 5,   addr_a: 9,   addr_b: 13,  tw: 32};
        vecs[4] = '{stage: 3, p: 10,  addr_a: 18,  addr_b: 26,  tw: 32};
        vecs[5] = '{stage: 6, p: 100, addr_a: 164, addr_b: 228, tw: 72};
        vecs[6] = '{stage: 0, p: 127, addr_a: 254, addr_b: 255, tw: 0};
        vecs[7] = '{stage: 7, p: 127, addr_a: 127, addr_b: 255, tw: 127};

        // Reset state.
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.bf_ready = 1'b0;
        bus.bf_done  = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        step();
        check("reset bf_valid", 32'(bus.bf_valid), 0);
        check("reset busy",     32'(bus.busy),     0);
        check("reset done",     32'(bus.done),     0);
        check("reset err",      32'(bus.err),      0);
        check("reset addr_a",   32'(bus.addr_a),   0);
        check("reset addr_b",   32'(bus.addr_b),   0);
        check("reset tw_idx",   32'(bus.tw_idx),   0);
        check("reset stage",    32'(bus.stage),    0);

        // Full transform, bf_ready held high.
        run_transform(1'b0, -1, -1, "full");
        for (int s = 0; s < LOG2N; s++) begin
            check($sformatf("full stage %0d bf_valid count", s), 32'(vcount[s]), HALF);
        end
        for (int i = 0; i < 8; i++) begin
            check($sformatf("vec s%0d p%0d addr_a", vecs[i].stage, vecs[i].p),
                  32'(obs_a[vecs[i].stage][vecs[i].p]), 32'(vecs[i].addr_a));
            check($sformatf("vec s%0d p%0d addr_b", vecs[i].stage, vecs[i].p),
                  32'(obs_b[vecs[i].stage][vecs[i].p]), 32'(vecs[i].addr_b));
            check($sformatf("vec s%0d p%0d tw_idx", vecs[i].stage, vecs[i].p),
                  32'(obs_tw[vecs[i].stage][vecs[i].p]), 32'(vecs[i].tw));
        end

        // bf_ready toggling 1010...
        run_transform(1'b1, -1, -1, "toggle");
        check("toggle stage0 issue span", 32'(last_v0 - first_v0 + 1), 255);
        check("toggle stage0 bf_valid count", 32'(vcount[0]), HALF);

        // start re-pulsed mid stage 3 is ignored.
        run_transform(1'b0, 3, -1, "restart");

        // Reset at stage 4, p=60 aborts with no done.
        run_transform(1'b0, -1, 4, "abort");
        check("abort happened", 32'(aborted), 1);
        check("abort busy",     32'(bus.busy),     0);
        check("abort done",     32'(bus.done),     0);
        check("abort bf_valid", 32'(bus.bf_valid), 0);
        check("abort addr_a",   32'(bus.addr_a),   0);
        check("abort addr_b",   32'(bus.addr_b),   0);
        check("abort tw_idx",   32'(bus.tw_idx),   0);
        check("abort stage",    32'(bus.stage),    0);
        check("abort err",      32'(bus.err),      0);
        base     = total_valids();
        done_cnt = 0;
        repeat (10) begin
            step();
            cycle_io(1'b0);
        end
        check("abort no done after", 32'(done_cnt), 0);
        check("abort no bf_valid after", 32'(total_valids() - base), 0);

        // Stray bf_done in IDLE sets a sticky err, cleared by the next start.
        bus.bf_done = 1'b1;
        step();
        bus.bf_done = 1'b0;
        check("idle bf_done err set", 32'(bus.err), 1);
        repeat (5) step();
        check("idle err sticky", 32'(bus.err), 1);
        check("idle err busy", 32'(bus.busy), 0);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("start clears err", 32'(bus.err), 0);
        check("start sets busy", 32'(bus.busy), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("final reset busy", 32'(bus.busy), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
